// File: rtl/small_comb_logic_dec_sv.sv
// small_comb_logic_dec_sv: receive-side decoder for the 8-bit small-comb-logic
// encoded word. Recovers the data byte, flags inconsistent (err) and
// ambiguous (amb) words, and keeps saturating err/amb counters. One registered
// valid/ready stage; enc_data never reaches dec_* combinationally.
module small_comb_logic_dec_sv #(
    parameter int unsigned CNT_W   = 8,
    parameter logic [1:0]  AMB_SEL = 2'b10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       enc_data,
    input  logic             enc_valid,
    output logic             enc_ready,
    output logic [7:0]       dec_data,
    output logic             dec_err,
    output logic             dec_amb,
    output logic             dec_valid,
    input  logic             dec_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] amb_cnt
);

    logic [7:0]       dec_data_q, dec_data_d;
    logic             dec_err_q, dec_err_d;
    logic             dec_amb_q, dec_amb_d;
    logic             dec_valid_q;
    logic [CNT_W-1:0] err_cnt_q, amb_cnt_q;
    logic             accept;
    logic [1:0]       d_lo, d_mid, d_sum;
    logic             sum_bad, pair_illegal;

    assign enc_ready = !dec_valid_q || dec_ready;
    assign accept    = enc_valid && enc_ready;

    // Decode the incoming word; the result is only ever consumed by the register stage
    always_comb begin
        d_lo         = {~enc_data[1], enc_data[0]};
        d_mid        = enc_data[3:2] ^ d_lo;
        d_sum        = d_lo + d_mid;
        sum_bad      = (d_sum != enc_data[5:4]);
        pair_illegal = 1'b0;
        dec_amb_d    = 1'b0;
        dec_data_d   = {2'b00, 2'b00, d_mid, d_lo};
        case (enc_data[7:6])
            2'b00: dec_data_d[7:6] = 2'b00;
            2'b11: dec_data_d[7:6] = 2'b11;
            2'b10: begin
                dec_data_d[7:6] = AMB_SEL;
                dec_amb_d       = 1'b1;
            end
            default: pair_illegal = 1'b1;
        endcase
        dec_err_d = sum_bad || pair_illegal;
    end

    // Output stage: load on accept, drop valid once drained, hold data otherwise
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            dec_err_q   <= 1'b0;
            dec_amb_q   <= 1'b0;
        end else if (accept) begin
            dec_valid_q <= 1'b1;
            dec_data_q  <= dec_data_d;
            dec_err_q   <= dec_err_d;
            dec_amb_q   <= dec_amb_d;
        end else if (dec_ready) begin
            dec_valid_q <= 1'b0;
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr) begin
            err_cnt_q <= '0;
            amb_cnt_q <= '0;
        end else if (accept) begin
            if (dec_err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (dec_amb_d && (amb_cnt_q != '1)) amb_cnt_q <= amb_cnt_q + CNT_W'(1);
        end
    end

    assign dec_data  = dec_data_q;
    assign dec_err   = dec_err_q;
    assign dec_amb   = dec_amb_q;
    assign dec_valid = dec_valid_q;
    assign err_cnt   = err_cnt_q;
    assign amb_cnt   = amb_cnt_q;

endmodule
